// File: rtl/inv_key_schedule_pkg.sv
// Shared types and constants for the inverse AES key schedule.
package inv_key_schedule_pkg;

  typedef enum logic [1:0] {IDLE, FWD, EMIT, BWD} ks_state_e;

  function automatic int nr_from_nk(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant k lands in byte 0, the most significant byte of the word.
  function automatic logic [31:0] rcon_word(input logic [3:0] k);
    logic [7:0] rc;
    case (k)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h0};
  endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// Key-in / round-key-out handshake bundle for the inverse key schedule.
interface inv_key_schedule_if #(
  parameter int Nk = 4
);
  logic              Start;
  logic [0:32*Nk-1]  Key;
  logic              Busy;
  logic              Rk_valid;
  logic              Rk_ready;
  logic [0:127]      Rk_out;
  logic [3:0]        Rk_idx;
  logic              Done;

  modport master (
    output Start, Key, Rk_ready,
    input  Busy, Rk_valid, Rk_out, Rk_idx, Done
  );

  modport slave (
    input  Start, Key, Rk_ready,
    output Busy, Rk_valid, Rk_out, Rk_idx, Done
  );
endinterface

// File: rtl/inv_key_schedule_sbox.sv
// Combinational AES forward S-box, one byte.
module inv_key_schedule_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the bit offset is 8*(255-a).
  logic [10:0] base;
  assign base = {~a_i, 3'b000};
  assign y_o  = SBOX[base +: 8];
endmodule

// File: rtl/inv_key_schedule.sv
// Inverse AES key schedule: walk an Nk-word window forward to the end of the
// expansion, then roll it back four words per emitted round key (Nr .. 0).
module inv_key_schedule
  import inv_key_schedule_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = nr_from_nk(Nk)
) (
  input logic               clk,
  input logic               rst_n,
  inv_key_schedule_if.slave bus
);
  localparam logic [5:0] NK_W     = 6'(Nk);
  localparam logic [5:0] LAST_FWD = 6'(4 * (Nr + 1) - 1);

  ks_state_e           state_q, state_d;
  logic [Nk-1:0][31:0] win_q, win_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [3:0]          r_q, r_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic                done_q, done_d;

  logic        bwd;
  logic [5:0]  fidx, fmod, fdiv;
  logic [31:0] f_in, sb_in, sb_out, f_out, new_w;

  // cnt_q is one past the top window index; BWD re-derives the top word's f.
  assign bwd   = (state_q == BWD);
  assign fidx  = bwd ? cnt_q - 6'd1 : cnt_q;
  assign fmod  = fidx % NK_W;
  assign fdiv  = fidx / NK_W;
  assign f_in  = bwd ? win_q[Nk-2] : win_q[Nk-1];
  assign sb_in = (fmod == 6'd0) ? rot_word(f_in) : f_in;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    inv_key_schedule_sbox u_sbox (
      .a_i (sb_in[8*b +: 8]),
      .y_o (sb_out[8*b +: 8])
    );
  end

  always_comb begin
    if (fmod == 6'd0)                f_out = sb_out ^ rcon_word(4'(fdiv - 6'd1));
    else if (Nk > 6 && fmod == 6'd4) f_out = sb_out;
    else                             f_out = f_in;
  end

  assign new_w = (bwd ? win_q[Nk-1] : win_q[0]) ^ f_out;

  // Near round 0 the low window slots fill with don't-care words below w[0];
  // only the top four slots are ever emitted.
  always_comb begin
    win_d  = win_q;
    cnt_d  = cnt_q;
    r_d    = r_q;
    bcnt_d = bcnt_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.Start) begin
        for (int k = 0; k < Nk; k++) win_d[k] = bus.Key[32*k +: 32];
        cnt_d = NK_W;
      end
      FWD: begin
        for (int k = 0; k < Nk-1; k++) win_d[k] = win_q[k+1];
        win_d[Nk-1] = new_w;
        cnt_d       = cnt_q + 6'd1;
        if (cnt_q == LAST_FWD) r_d = 4'(Nr);
      end
      EMIT: if (bus.Rk_ready) begin
        if (r_q == 4'd0) done_d = 1'b1;
        else             r_d    = r_q - 4'd1;
        bcnt_d = 2'd0;
      end
      BWD: begin
        for (int k = 1; k < Nk; k++) win_d[k] = win_q[k-1];
        win_d[0] = new_w;
        cnt_d    = cnt_q - 6'd1;
        bcnt_d   = bcnt_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q  <= '0;
      cnt_q  <= '0;
      r_q    <= '0;
      bcnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      win_q  <= win_d;
      cnt_q  <= cnt_d;
      r_q    <= r_d;
      bcnt_q <= bcnt_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.Start) state_d = FWD;
      FWD:     if (cnt_q == LAST_FWD) state_d = EMIT;
      EMIT:    if (bus.Rk_ready) state_d = (r_q == 4'd0) ? IDLE : BWD;
      BWD:     if (bcnt_q == 2'd3) state_d = EMIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.Busy     = (state_q != IDLE);
    bus.Rk_valid = (state_q == EMIT);
    bus.Rk_idx   = r_q;
    bus.Rk_out   = {win_q[Nk-4], win_q[Nk-3], win_q[Nk-2], win_q[Nk-1]};
    bus.Done     = done_q;
  end
endmodule
